cs_out_checker: RTL and testbench
=================================

Name: cs_out_checker

Overview:
- Synthesizable consumer at the Y end of the CS sliding-window averager. Samples CS's 10-bit Y output on every rising clock edge after a start pulse.
- Discards the pipeline-fill samples, then compares each subsequent Y against a golden value fetched from an external synchronous ROM.
- Reports mismatch count, the index of the first mismatch, and pass/done status.
- Used for on-chip/FPGA self-test and in gate-level runs beside CS.

Parameters:
- WARMUP, 8, number of Y samples discarded after start (window fill).
- N_CHK, 1992, number of Y samples compared (indices 0..N_CHK-1).
- AW, 11, golden ROM address width; must satisfy 2^AW >= N_CHK.
- ERR_W, 12, width of the error counter (saturating).

Ports:
- clk, input, 1, system clock; all sampling on posedge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a check run.
- Y, input, 10, CS output under test.
- gold_rd, output, 1, golden ROM read enable.
- gold_addr, output, AW, golden ROM address.
- gold_data, input, 10, golden ROM data; valid the cycle after the edge that captured gold_addr/gold_rd.
- busy, output, 1, high in WARM, CHECK, FLUSH.
- done, output, 1, high in DONE.
- pass, output, 1, high in DONE when err_cnt==0.
- err_cnt, output, ERR_W, mismatch count, saturating at all-ones.
- first_err_idx, output, AW, index of first mismatch.
- first_err_vld, output, 1, first_err_idx is valid.

Behaviour:
- Reset (async, any state): state=IDLE; all counters and outputs 0 (gold_rd=0, gold_addr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, first_err_vld=0). Internal y_q and cmp_vld cleared. A reset mid-run aborts the run; no partial result is retained.
- States: IDLE, WARM, CHECK, FLUSH, DONE.
- IDLE: start=1 at a posedge -> WARM; clears warm_cnt, chk_cnt, err_cnt, first_err_*.
- WARM: warm_cnt increments each posedge. After WARMUP edges in WARM -> CHECK. If WARMUP=0, go straight from IDLE to CHECK.
- CHECK:
  - gold_rd=1; gold_addr=chk_cnt (registered).
  - At each posedge: y_q<=Y, cmp_vld<=1, chk_cnt<=chk_cnt+1.
  - The edge that captures sample N_CHK-1 -> FLUSH (chk_cnt does not wrap).
- Compare stage, at every posedge with cmp_vld=1:
  - If y_q != gold_data: err_cnt increments unless already all-ones.
  - On the first mismatch: first_err_idx<=index of y_q (chk_cnt-1 at capture), first_err_vld<=1. Later mismatches never overwrite it.
- FLUSH: gold_rd=0; final compare is performed; cmp_vld<=0 -> DONE.
- DONE: done=1; pass=(err_cnt==0); results held stable. start=1 -> WARM with all results cleared (same as IDLE start).
- Start while busy is ignored.
- Latency: a start at edge t0 gives done=1 after edge t0+WARMUP+N_CHK+1.
- Comparison is exact 10-bit unsigned equality. No tolerance.

Test Plan:
- Golden ROM == model Y stream, WARMUP=8, N_CHK=16 -> done exactly 25 edges after start; pass=1; err_cnt=0; first_err_vld=0; gold_addr steps 0..15.
- Y corrupted (0x155 vs golden 0x154) only at index 5 -> err_cnt=1, first_err_idx=5, first_err_vld=1, pass=0.
- Mismatches at index 0 and index N_CHK-1 -> err_cnt=2, first_err_idx=0. Confirms first and last samples are compared and warm-up samples are not (corrupt sample before index 0 -> no error).
- ERR_W=2 with every sample wrong, N_CHK=16 -> err_cnt saturates at 3, pass=0.
- Reset asserted mid-CHECK at index 7 -> all outputs 0 immediately (async), state IDLE. A new start then yields a clean full run with pass=1.
- start pulsed during CHECK -> ignored, run completes normally. start in DONE -> results cleared, second run completes with the same latency.

Source files
------------

// File: rtl/cs_out_checker.sv
// cs_out_checker: discards CS window-fill samples, then compares each Y against a golden ROM stream.
module cs_out_checker #(
  parameter int WARMUP = 8,
  parameter int N_CHK  = 1992,
  parameter int AW     = 11,
  parameter int ERR_W  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [9:0]       Y,
  output logic             gold_rd,
  output logic [AW-1:0]    gold_addr,
  input  logic [9:0]       gold_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_vld
);
  typedef enum logic [2:0] {IDLE, WARM, CHECK, FLUSH, DONE} state_t;
  localparam int WW = WARMUP > 1 ? $clog2(WARMUP) : 1;
  state_t        r_state, w_next;
  logic [WW-1:0] r_warm_cnt;
  logic [AW-1:0] r_chk_cnt, r_idx_q;
  logic [9:0]    r_y_q;
  logic          r_cmp_vld;
  logic          w_go, w_warm_last, w_chk_last, w_mis;
  assign w_go        = start && (r_state == IDLE || r_state == DONE);
  assign w_warm_last = r_warm_cnt == WW'(WARMUP - 1);
  assign w_chk_last  = r_chk_cnt == AW'(N_CHK - 1);
  assign w_mis       = r_cmp_vld && (r_y_q != gold_data);
  assign gold_rd     = r_state == CHECK;
  assign gold_addr   = r_chk_cnt;
  assign busy        = r_state == WARM || r_state == CHECK || r_state == FLUSH;
  assign done        = r_state == DONE;
  assign pass        = done && err_cnt == '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_go ? (WARMUP == 0 ? CHECK : WARM) : r_state;
      WARM:       w_next = w_warm_last ? CHECK : WARM;
      CHECK:      w_next = w_chk_last ? FLUSH : CHECK;
      FLUSH:      w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_warm_cnt    <= '0;
      r_chk_cnt     <= '0;
      r_idx_q       <= '0;
      r_y_q         <= '0;
      r_cmp_vld     <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cmp_vld <= r_state == CHECK;
      if (r_state == WARM) r_warm_cnt <= r_warm_cnt + 1'b1;
      // sample index travels with y_q so the last index never needs chk_cnt to reach N_CHK
      if (r_state == CHECK) begin
        r_y_q   <= Y;
        r_idx_q <= r_chk_cnt;
        if (!w_chk_last) r_chk_cnt <= r_chk_cnt + 1'b1;
      end
      if (w_go) begin
        r_warm_cnt    <= '0;
        r_chk_cnt     <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        first_err_vld <= 1'b0;
      end else if (w_mis) begin
        if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
        if (!first_err_vld) begin
          first_err_idx <= r_idx_q;
          first_err_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cs_out_checker.sv
// tb_cs_out_checker: directed runs against a golden ROM model, scoreboarded on the rising edge of done.
module tb_cs_out_checker;
  localparam int AW = 4;
  localparam int NC = 16;
  localparam int LAT = 8 + NC + 1;
  typedef struct {int err; int idx; bit vld; bit pass;} exp_t;
  logic clk = 1'b0, reset, start;
  logic [9:0] y, y_sat, gold_data, gold_data_s;
  logic gold_rd, busy, done, pass, fvld;
  logic [AW-1:0] gold_addr, fidx;
  logic [11:0] err_cnt;
  logic gold_rd_s, busy_s, done_s, pass_s, fvld_s;
  logic [AW-1:0] gold_addr_s, fidx_s;
  logic [1:0] err_cnt_s;
  logic [9:0] gold [NC];
  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, t_start = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign y_sat = y ^ 10'h3FF;
  cs_out_checker #(.WARMUP(8), .N_CHK(NC), .AW(AW), .ERR_W(12)) u_dut (
    .clk(clk), .reset(reset), .start(start), .Y(y), .gold_rd(gold_rd), .gold_addr(gold_addr),
    .gold_data(gold_data), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(fidx), .first_err_vld(fvld));
  cs_out_checker #(.WARMUP(8), .N_CHK(NC), .AW(AW), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .Y(y_sat), .gold_rd(gold_rd_s), .gold_addr(gold_addr_s),
    .gold_data(gold_data_s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
    .first_err_idx(fidx_s), .first_err_vld(fvld_s));
  always @(posedge clk) if (gold_rd) gold_data <= gold[gold_addr];
  always @(posedge clk) if (gold_rd_s) gold_data_s <= gold[gold_addr_s];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_dut_outs"}, int'({gold_rd, gold_addr, busy, done, pass, err_cnt, fidx, fvld}), 0);
    chk({tag, "_sat_outs"}, int'({gold_rd_s, gold_addr_s, busy_s, done_s, pass_s, err_cnt_s, fidx_s, fvld_s}), 0);
  endtask
  // Monitor: gold_addr must walk 0..NC-1 during CHECK; each done rising edge pops one expectation.
  initial begin
    int exp_addr = 0;
    bit done_d = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (gold_rd) begin
        chk("gold_addr", int'(gold_addr), exp_addr);
        exp_addr++;
      end else exp_addr = 0;
      if (done && !done_d) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("latency", cyc - t_start, LAT);
          chk("err_cnt", int'(err_cnt), e.err);
          chk("first_err_idx", int'(fidx), e.idx);
          chk("first_err_vld", int'(fvld), int'(e.vld));
          chk("pass", int'(pass), int'(e.pass));
          chk("sat_done", int'(done_s), 1);
          chk("sat_err_cnt", int'(err_cnt_s), 3);
          chk("sat_first_idx", int'(fidx_s), 0);
          chk("sat_pass", int'(pass_s), 0);
        end
      end
      done_d = done;
    end
  end
  task automatic run(input int bad0, input int bad1, input bit warm_bad, input int start_at,
                     input int abort_at, input exp_t e);
    @(negedge clk);
    start = 1'b1;
    if (abort_at < 0) begin
      exp_q.push_back(e);
      t_start = cyc + 1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_done_clr", int'(done), 0);
    chk("start_err_clr", int'(err_cnt), 0);
    chk("start_vld_clr", int'(fvld), 0);
    chk("start_sat_err_clr", int'(err_cnt_s), 0);
    for (int i = 0; i < 8; i++) begin
      y = warm_bad ? 10'h3A5 : gold[i];
      @(negedge clk);
    end
    for (int k = 0; k < NC; k++) begin
      y = gold[k] ^ ((k == bad0 || k == bad1) ? 10'h001 : 10'h000);
      start = (k == start_at);
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1 chk_zero("abort");
        @(negedge clk);
        chk_zero("abort_hold");
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask
  task automatic wait_results(input string name);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < NC; k++) gold[k] = 10'h14F + 10'(k * 3);
    gold[5] = 10'h154;
    reset = 1'b1;
    start = 1'b0;
    y = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    run(-1, -1, 0, -1, -1, '{0, 0, 0, 1});
    wait_results("clean");
    run(5, -1, 0, -1, -1, '{1, 5, 1, 0});
    wait_results("idx5");
    run(0, NC - 1, 1, -1, -1, '{2, 0, 1, 0});
    wait_results("ends");
    run(2, -1, 0, -1, 7, '{0, 0, 0, 0});
    run(-1, -1, 0, -1, -1, '{0, 0, 0, 1});
    wait_results("after_abort");
    run(-1, -1, 0, 4, -1, '{0, 0, 0, 1});
    wait_results("start_in_check");
    run(9, -1, 0, -1, -1, '{1, 9, 1, 0});
    wait_results("pre_restart");
    repeat (3) @(negedge clk);
    chk("held_done", int'(done), 1);
    chk("held_err", int'(err_cnt), 1);
    chk("held_idx", int'(fidx), 9);
    run(-1, -1, 0, -1, -1, '{0, 0, 0, 1});
    wait_results("restart");
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
